// File: rtl/subleq_control_if.sv
// Bundles the control FSM's run-control inputs, datapath flags/data, strobes
// and status outputs. The controller uses the master modport; the datapath
// side (or a testbench) uses the slave modport.
interface subleq_control_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic              start;
  logic              step_mode;
  logic              zero;
  logic              negative;
  logic [DATA_W-1:0] mem_data_out;
  logic              a_ld;
  logic              b_ld;
  logic              c_ld;
  logic              mem_a_ld;
  logic              mem_b_ld;
  logic              result_ld;
  logic              mem_read;
  logic              mem_write;
  logic              pc_ld;
  logic [3:0]        state;
  logic              busy;
  logic              halted;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    input  start, step_mode, zero, negative, mem_data_out,
    output a_ld, b_ld, c_ld, mem_a_ld, mem_b_ld, result_ld,
           mem_read, mem_write, pc_ld, state, busy, halted, instr_count
  );

  modport slave (
    output start, step_mode, zero, negative, mem_data_out,
    input  a_ld, b_ld, c_ld, mem_a_ld, mem_b_ld, result_ld,
           mem_read, mem_write, pc_ld, state, busy, halted, instr_count
  );
endinterface

// File: rtl/subleq_control.sv
// SUBLEQ control FSM: walks the datapath through the 13-state instruction
// cycle, detects halt on a sentinel branch target, supports run/single-step
// and counts retired instructions.
module subleq_control #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] HALT_ADDR = {DATA_W{1'b1}},
  parameter int                CNT_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  subleq_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH_A     = 4'd0,
    LOAD_A      = 4'd1,
    FETCH_B     = 4'd2,
    LOAD_B      = 4'd3,
    FETCH_C     = 4'd4,
    LOAD_C      = 4'd5,
    FETCH_MEM_A = 4'd6,
    LOAD_MEM_A  = 4'd7,
    FETCH_MEM_B = 4'd8,
    LOAD_MEM_B  = 4'd9,
    EXECUTE     = 4'd10,
    WRITEBACK   = 4'd11,
    UPDATE_PC   = 4'd12,
    HALT        = 4'd13,
    IDLE        = 4'd14
  } state_e;

  state_e           state_q, state_d;
  logic             halt_cand_q;
  logic             halted_q;
  logic [CNT_W-1:0] count_q;

  // State register, halt candidate, sticky halt flag and retired counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      halt_cand_q <= 1'b0;
      halted_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALT);
      if (state_q == UPDATE_PC) begin
        count_q <= count_q + CNT_W'(1);
      end
      // A fresh instruction starts with no pending halt; the branch target
      // is compared when it is loaded.
      if (state_d == FETCH_A && state_q != FETCH_A) begin
        halt_cand_q <= 1'b0;
      end else if (state_q == LOAD_C) begin
        halt_cand_q <= (bus.mem_data_out == HALT_ADDR);
      end
    end
  end

  // Next-state logic: linear walk through the cycle, branch decision at UPDATE_PC.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_A, LOAD_A, FETCH_B, LOAD_B, FETCH_C, LOAD_C,
      FETCH_MEM_A, LOAD_MEM_A, FETCH_MEM_B, LOAD_MEM_B,
      EXECUTE, WRITEBACK:
        state_d = state_e'(state_q + 4'd1);
      UPDATE_PC: begin
        if (halt_cand_q && (bus.zero || bus.negative)) begin
          state_d = HALT;
        end else if (bus.step_mode) begin
          state_d = IDLE;
        end else begin
          state_d = FETCH_A;
        end
      end
      HALT:    state_d = HALT;
      IDLE:    state_d = bus.start ? FETCH_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore strobe decode from the current state only.
  always_comb begin
    bus.a_ld      = 1'b0;
    bus.b_ld      = 1'b0;
    bus.c_ld      = 1'b0;
    bus.mem_a_ld  = 1'b0;
    bus.mem_b_ld  = 1'b0;
    bus.result_ld = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.pc_ld     = 1'b0;
    case (state_q)
      FETCH_A, FETCH_B, FETCH_C, FETCH_MEM_A, FETCH_MEM_B:
        bus.mem_read = 1'b1;
      LOAD_A:     begin bus.mem_read = 1'b1; bus.a_ld     = 1'b1; end
      LOAD_B:     begin bus.mem_read = 1'b1; bus.b_ld     = 1'b1; end
      LOAD_C:     begin bus.mem_read = 1'b1; bus.c_ld     = 1'b1; end
      LOAD_MEM_A: begin bus.mem_read = 1'b1; bus.mem_a_ld = 1'b1; end
      LOAD_MEM_B: begin bus.mem_read = 1'b1; bus.mem_b_ld = 1'b1; end
      EXECUTE:    bus.result_ld = 1'b1;
      WRITEBACK:  bus.mem_write = 1'b1;
      UPDATE_PC:  bus.pc_ld     = 1'b1;
      default:    ;
    endcase
  end

  // Status outputs.
  assign bus.state       = state_q;
  assign bus.busy        = (4'(state_q) <= 4'd12);
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule

// File: doc/subleq_control.md
# subleq_control

Control FSM that sequences the 64-bit SUBLEQ datapath through its 13-state instruction cycle. It drives the datapath's register load enables, memory read/write strobes, `pc_ld` and the 4-bit `state` code, and samples the ALU `zero`/`negative` flags. It adds run/single-step control, halt detection on a sentinel branch target, and a retired-instruction counter for the top level and testbench.

## Interface
Parameters:
- `DATA_W`, 64, width of `mem_data_out` and of a memory word
- `HALT_ADDR`, 64'hFFFF_FFFF_FFFF_FFFF, branch target `c` that halts the machine when the branch is taken
- `CNT_W`, 32, width of `instr_count`

Ports:
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  run request; sampled only in IDLE
- `step_mode`  in  1  1 = return to IDLE after each instruction; sampled in UPDATE_PC
- `zero`  in  1  ALU zero flag (mem[b]-mem[a] == 0)
- `negative`  in  1  ALU negative flag (mem[b]-mem[a] < 0)
- `mem_data_out`  in  DATA_W  datapath memory read data
- `a_ld`, `b_ld`, `c_ld`, `mem_a_ld`, `mem_b_ld`, `result_ld`  out  1 each  datapath register load enables
- `mem_read`  out  1  memory read enable
- `mem_write`  out  1  memory write enable
- `pc_ld`  out  1  PC load/update enable
- `state`  out  4  current state code, fed to the datapath
- `busy`  out  1  high in states 0–12
- `halted`  out  1  sticky halt indication
- `instr_count`  out  CNT_W  instructions retired since reset

## Operation
- State codes: FETCH_A=0, LOAD_A=1, FETCH_B=2, LOAD_B=3, FETCH_C=4, LOAD_C=5, FETCH_MEM_A=6, LOAD_MEM_A=7, FETCH_MEM_B=8, LOAD_MEM_B=9, EXECUTE=10, WRITEBACK=11, UPDATE_PC=12, HALT=13, IDLE=14. Code 15 is illegal and goes to IDLE on the next edge.
- Transitions:
  - IDLE -> FETCH_A when `start`=1; otherwise stay in IDLE.
  - States 0–11 advance unconditionally to state+1.
  - UPDATE_PC -> HALT if `halt_cand` and (`zero`|`negative`).
  - Otherwise UPDATE_PC -> IDLE if `step_mode`=1, else FETCH_A.
  - HALT is absorbing; only `rst` leaves it.
- Output decode is Moore (function of `state` only):
  - `mem_read`=1 in states 0–9.
  - `a_ld` in LOAD_A, `b_ld` in LOAD_B, `c_ld` in LOAD_C, `mem_a_ld` in LOAD_MEM_A, `mem_b_ld` in LOAD_MEM_B.
  - `result_ld` in EXECUTE; `mem_write` in WRITEBACK; `pc_ld` in UPDATE_PC.
  - All strobes are 0 in IDLE, HALT and code 15.
- `halt_cand`: internal register. In LOAD_C it loads (`mem_data_out` == HALT_ADDR), full DATA_W compare. Cleared on reset and on entry to FETCH_A.
- `pc_ld` is asserted in UPDATE_PC even on the halting instruction, so PC reflects the taken branch.
- `instr_count` increments by 1 on every edge leaving UPDATE_PC, including the halting instruction. It wraps modulo 2^CNT_W with no saturation.
- `halted` = (state == HALT), registered. `busy` = state ≤ 12.

## Timing
- Reset: on the first `clk` edge with `rst`=1:
  - state=IDLE, `halt_cand`=0, `instr_count`=0.
  - All strobes 0, `busy`=0, `halted`=0.
  - `rst` overrides every other input and aborts any instruction in progress. A partially executed WRITEBACK is not rolled back.
- Every state lasts exactly one cycle.
- Continuous run: 13 cycles per instruction, back to back with no IDLE gap.
- Step mode: 13 cycles plus at least 1 IDLE cycle per instruction.
- Start latency: with `start` high in IDLE at edge N, FETCH_A holds during cycle N+1 and `busy` rises at N+1.
- Datapath captures register loads on the edge that ends each LOAD_x/EXECUTE state.
- Flag sampling: `zero`/`negative` are sampled at the edge ending UPDATE_PC. They are stable because mem_a/mem_b registers do not change after LOAD_MEM_B.
- Simultaneous events:
  - `start` outside IDLE is ignored.
  - Toggling `step_mode` mid-instruction takes effect only at that instruction's UPDATE_PC.
  - `start` and `rst` in the same cycle: `rst` wins.

## Test plan
- Reset: hold `rst` 2 cycles with `start`=1 -> state=14, all strobes 0, `instr_count`=0, `halted`=0; FETCH_A appears 1 cycle after `rst` falls.
- Strobe sequence: `start` pulse, `step_mode`=0 -> `state` runs 0..12, 0 (13-cycle period). Check:
  - `mem_read` high in cycles 0–9 of the instruction; `mem_write` only at state 11; `pc_ld` only at state 12.
  - Exactly one ld strobe each at states 1, 3, 5, 7, 9, 10.
- Single step: `step_mode`=1 -> IDLE after each UPDATE_PC. Three `start` pulses -> `instr_count`=3, 3×13 busy cycles.
- Halt taken: `mem_data_out`=64'hFFFF_FFFF_FFFF_FFFF in LOAD_C, `negative`=1 at UPDATE_PC -> HALT next cycle, `halted`=1, `instr_count` incremented, `pc_ld` seen once. Further `start` pulses do not change state.
- Halt not taken: same `c`, `zero`=0, `negative`=0 -> returns to FETCH_A, `halted`=0. A following instruction with `c`=5 and `zero`=1 also does not halt.
- Counter wrap and abort:
  - With `CNT_W`=4, 16 instructions -> `instr_count`=0.
  - Asserting `rst` during WRITEBACK -> IDLE next cycle, `mem_write` deasserted.
